// File: rtl/cpu_timer_io.sv
// cpu_timer_io: 16-byte memory-mapped I/O window on the 6809 CPU bus.
// Provides an LED latch and a prescaled 16-bit down-counter timer with an
// active-low interrupt output. Reads are zero-latency (combinational data).
module cpu_timer_io #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    input  logic        cpu_oe_i,
    output logic [7:0]  io_data_o,
    output logic        io_sel_o,
    output logic [7:0]  leds_o,
    output logic        irq_n_o
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    localparam logic [3:0] OFF_LED    = 4'd0;
    localparam logic [3:0] OFF_CTRL   = 4'd1;
    localparam logic [3:0] OFF_STATUS = 4'd2;
    localparam logic [3:0] OFF_PRE    = 4'd3;
    localparam logic [3:0] OFF_RHI    = 4'd4;
    localparam logic [3:0] OFF_RLO    = 4'd5;
    localparam logic [3:0] OFF_CHI    = 4'd6;
    localparam logic [3:0] OFF_CLO    = 4'd7;

    logic [DW-1:0] leds;
    logic          en;
    logic          auto_rl;
    logic          ie;
    logic          exp_flag;
    logic [DW-1:0] prescale;
    logic [DW-1:0] hold;
    logic [CW-1:0] reload;
    logic [CW-1:0] count;
    logic [DW-1:0] snap;
    logic [DW-1:0] pc;

    logic       hit;
    logic [3:0] off;
    logic       wr;
    logic       rd;
    logic       wr_ctrl;
    logic       wr_rlo;
    logic       tick;
    logic       tick_ok;
    logic       expire;

    assign hit     = (cpu_addr_i[15:4] == BASE_ADDR[15:4]);
    assign off     = cpu_addr_i[3:0];
    assign wr      = cpu_we_i & hit;
    // A simultaneous write suppresses read side effects.
    assign rd      = cpu_oe_i & hit & ~cpu_we_i;
    assign wr_ctrl = wr && (off == OFF_CTRL);
    assign wr_rlo  = wr && (off == OFF_RLO);

    // Prescaler rollover; a CTRL or RELOAD_LO write in the same cycle discards it.
    assign tick    = en && (pc >= prescale);
    assign tick_ok = tick && !wr_ctrl && !wr_rlo;
    assign expire  = tick_ok && (count == '0);

    assign io_sel_o = hit & (cpu_we_i | cpu_oe_i);
    assign leds_o   = leds;
    assign irq_n_o  = ~(exp_flag & ie);

    // Read data mux, shows pre-write register contents during the strobe cycle.
    always_comb begin
        io_data_o = '0;
        if (cpu_oe_i && hit) begin
            unique case (off)
                OFF_LED:    io_data_o = leds;
                OFF_CTRL:   io_data_o = {5'b0, ie, auto_rl, en};
                OFF_STATUS: io_data_o = {en, 6'b0, exp_flag};
                OFF_PRE:    io_data_o = prescale;
                OFF_RHI:    io_data_o = reload[15:8];
                OFF_RLO:    io_data_o = reload[7:0];
                OFF_CHI:    io_data_o = count[15:8];
                OFF_CLO:    io_data_o = snap;
                default:    io_data_o = '0;
            endcase
        end
    end

    // Register file, prescaler and down-counter state.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            leds     <= '0;
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            exp_flag <= 1'b0;
            prescale <= '0;
            hold     <= '0;
            reload   <= '0;
            count    <= '0;
            snap     <= '0;
            pc       <= '0;
        end else begin
            if (wr && off == OFF_LED) leds <= cpu_data_i;
            if (wr && off == OFF_PRE) prescale <= cpu_data_i;
            if (wr && off == OFF_RHI) hold <= cpu_data_i;
            if (rd && off == OFF_CHI) snap <= count[7:0];

            // Expiry set takes priority over a W1C clear.
            if (expire) begin
                exp_flag <= 1'b1;
            end else if (wr && off == OFF_STATUS && cpu_data_i[0]) begin
                exp_flag <= 1'b0;
            end

            if (wr_ctrl) begin
                en      <= cpu_data_i[0];
                auto_rl <= cpu_data_i[1];
                ie      <= cpu_data_i[2];
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            if (wr_rlo) begin
                reload <= {hold, cpu_data_i};
                count  <= {hold, cpu_data_i};
                pc     <= '0;
            end else if (wr_ctrl || !en) begin
                pc <= '0;
            end else if (tick) begin
                pc <= '0;
                if (count != '0) begin
                    count <= CW'(count - CW'(1));
                end else if (auto_rl) begin
                    count <= reload;
                end
            end else begin
                pc <= DW'(pc + DW'(1));
            end
        end
    end

endmodule

// File: tb/tb_cpu_timer_io.sv
// Directed self-checking bench for cpu_timer_io.
module tb_cpu_timer_io;

    logic        cpu_clk;
    logic        cpu_reset;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_we_i;
    logic        cpu_oe_i;
    logic [7:0]  io_data_o;
    logic        io_sel_o;
    logic [7:0]  leds_o;
    logic        irq_n_o;

    int errors = 0;
    int checks = 0;

    cpu_timer_io #(.BASE_ADDR(16'hFF00)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_reset  (cpu_reset),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_oe_i   (cpu_oe_i),
        .io_data_o  (io_data_o),
        .io_sel_o   (io_sel_o),
        .leds_o     (leds_o),
        .irq_n_o    (irq_n_o)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        we;
        logic        oe;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        logic        exp_sel;
        logic [7:0]  exp_leds;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        cpu_we_i   = 1'b0;
        cpu_oe_i   = 1'b0;
        cpu_addr_i = 16'h0000;
        cpu_data_i = 8'h00;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we_i = 1'b1; cpu_oe_i = 1'b0; cpu_addr_i = a; cpu_data_i = d;
        step();
        idle();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        cpu_we_i = 1'b0; cpu_oe_i = 1'b1; cpu_addr_i = a; cpu_data_i = 8'h00;
        #2;
        d = io_data_o;
        step();
        idle();
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, 16'(d), 16'(exp));
    endtask

    initial begin
        logic [7:0] d;
        int n;

        vecs[0]  = '{1'b1, 1'b0, 16'hFF00, 8'hA5, 8'h00, 1'b1, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 16'hFF00, 8'h00, 8'hA5, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 1'b0, 16'hFF10, 8'h5A, 8'h00, 1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 1'b1, 16'hFF10, 8'h00, 8'h00, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 1'b1, 16'hFF00, 8'h00, 8'hA5, 1'b1, 8'hA5};
        vecs[5]  = '{1'b1, 1'b0, 16'hFF03, 8'h03, 8'h00, 1'b1, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 16'hFF03, 8'h00, 8'h03, 1'b1, 8'hA5};
        vecs[7]  = '{1'b1, 1'b1, 16'hFF01, 8'h02, 8'h00, 1'b1, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 16'hFF01, 8'h00, 8'h02, 1'b1, 8'hA5};
        vecs[9]  = '{1'b1, 1'b0, 16'hFF01, 8'hF8, 8'h00, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 1'b1, 16'hFF01, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[11] = '{1'b1, 1'b0, 16'hFF04, 8'hAB, 8'h00, 1'b1, 8'hA5};
        vecs[12] = '{1'b0, 1'b1, 16'hFF04, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[13] = '{1'b1, 1'b0, 16'hFF05, 8'hCD, 8'h00, 1'b1, 8'hA5};
        vecs[14] = '{1'b0, 1'b1, 16'hFF04, 8'h00, 8'hAB, 1'b1, 8'hA5};
        vecs[15] = '{1'b0, 1'b1, 16'hFF05, 8'h00, 8'hCD, 1'b1, 8'hA5};
        vecs[16] = '{1'b0, 1'b1, 16'hFF06, 8'h00, 8'hAB, 1'b1, 8'hA5};
        vecs[17] = '{1'b0, 1'b1, 16'hFF07, 8'h00, 8'hCD, 1'b1, 8'hA5};
        vecs[18] = '{1'b1, 1'b0, 16'hFF08, 8'hFF, 8'h00, 1'b1, 8'hA5};
        vecs[19] = '{1'b0, 1'b1, 16'hFF08, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[20] = '{1'b0, 1'b1, 16'hFF02, 8'h00, 8'h00, 1'b1, 8'hA5};
        vecs[21] = '{1'b0, 1'b0, 16'hFF00, 8'h00, 8'h00, 1'b0, 8'hA5};

        // Reset and empty register window
        idle();
        cpu_reset = 1'b1;
        step();
        step();
        cpu_reset = 1'b0;
        check("rst_leds", 16'(leds_o), 16'h0000);
        check("rst_irq_n", 16'(irq_n_o), 16'h0001);
        check("rst_sel", 16'(io_sel_o), 16'h0000);
        for (int i = 0; i < 16; i++) begin
            read_check($sformatf("rst_read_%0d", i), 16'hFF00 + 16'(i), 8'h00);
        end

        // Table-driven register access vectors
        for (int i = 0; i < NVEC; i++) begin
            cpu_we_i   = vecs[i].we;
            cpu_oe_i   = vecs[i].oe;
            cpu_addr_i = vecs[i].addr;
            cpu_data_i = vecs[i].wdata;
            #2;
            check($sformatf("vec%0d_data", i), 16'(io_data_o), 16'(vecs[i].exp_data));
            check($sformatf("vec%0d_sel", i), 16'(io_sel_o), 16'(vecs[i].exp_sel));
            step();
            idle();
            check($sformatf("vec%0d_leds", i), 16'(leds_o), 16'(vecs[i].exp_leds));
        end

        // One-shot expiry: period (4+1)*(3+1) = 20 cycles
        bus_write(16'hFF03, 8'h03);
        bus_write(16'hFF04, 8'h00);
        bus_write(16'hFF05, 8'h04);
        read_check("oneshot_reload_lo", 16'hFF05, 8'h04);
        bus_write(16'hFF01, 8'h05);
        n = 0;
        while (irq_n_o !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        check("oneshot_period", 16'(n), 16'd20);
        read_check("oneshot_status", 16'hFF02, 8'h01);
        read_check("oneshot_count_hi", 16'hFF06, 8'h00);
        read_check("oneshot_count_lo", 16'hFF07, 8'h00);

        // Autoreload: reload to 4, W1C clears irq, next expiry 20 cycles later
        bus_write(16'hFF02, 8'h01);
        check("w1c_irq_n", 16'(irq_n_o), 16'h0001);
        bus_write(16'hFF05, 8'h04);
        bus_write(16'hFF01, 8'h07);
        n = 0;
        while (irq_n_o !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        check("auto_period1", 16'(n), 16'd20);
        read_check("auto_count_hi", 16'hFF06, 8'h00);
        read_check("auto_count_lo", 16'hFF07, 8'h04);
        bus_write(16'hFF02, 8'h01);
        n += 3;
        check("auto_w1c_irq_n", 16'(irq_n_o), 16'h0001);
        while (irq_n_o !== 1'b0 && n < 80) begin
            step();
            n++;
        end
        check("auto_period2", 16'(n), 16'd40);
        read_check("auto_status_en", 16'hFF02, 8'h81);

        // Coherent 16-bit count snapshot across a low-byte borrow
        bus_write(16'hFF01, 8'h00);
        bus_write(16'hFF02, 8'h01);
        bus_write(16'hFF03, 8'h00);
        bus_write(16'hFF04, 8'h12);
        bus_write(16'hFF05, 8'h03);
        bus_write(16'hFF01, 8'h01);
        step(); step(); step();
        read_check("snap_hi", 16'hFF06, 8'h12);
        step(); step(); step(); step();
        read_check("snap_lo", 16'hFF07, 8'h00);
        // Simultaneous write and read of COUNT_HI: no snapshot update
        cpu_we_i = 1'b1; cpu_oe_i = 1'b1; cpu_addr_i = 16'hFF06; cpu_data_i = 8'h55;
        #2;
        check("wr_rd_count_hi", 16'(io_data_o), 16'h0011);
        step();
        idle();
        read_check("snap_kept", 16'hFF07, 8'h00);

        // W1C in the same cycle as an expiry: set wins
        bus_write(16'hFF01, 8'h00);
        bus_write(16'hFF02, 8'h01);
        bus_write(16'hFF04, 8'h00);
        bus_write(16'hFF05, 8'h02);
        bus_write(16'hFF01, 8'h05);
        step(); step();
        bus_write(16'hFF02, 8'h01);
        check("w1c_collide_irq_n", 16'(irq_n_o), 16'h0000);
        read_check("w1c_collide_status", 16'hFF02, 8'h01);
        bus_write(16'hFF02, 8'h01);
        check("w1c_after_irq_n", 16'(irq_n_o), 16'h0001);

        // Reset asserted mid-count
        bus_write(16'hFF00, 8'h3C);
        bus_write(16'hFF04, 8'h01);
        bus_write(16'hFF05, 8'h00);
        bus_write(16'hFF01, 8'h07);
        for (int i = 0; i < 5; i++) step();
        cpu_reset = 1'b1;
        step();
        cpu_reset = 1'b0;
        check("midrst_leds", 16'(leds_o), 16'h0000);
        check("midrst_irq_n", 16'(irq_n_o), 16'h0001);
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("midrst_read_%0d", i), 16'hFF00 + 16'(i), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
